// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control bus between mc_ctrl and the multicycle datapath
interface mc_ctrl_if #(
    parameter int ALUCTRL_W = 3
);
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_we;
    logic                 ir_we;
    logic                 reg_we;
    logic                 mem_rd;
    logic                 mem_wr;
    logic                 iord;
    logic                 reg_dst;
    logic                 mem_to_reg;
    logic                 alu_src_a;
    logic                 ext_sign;
    logic [1:0]           alu_src_b;
    logic [1:0]           pc_src;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 illegal;
    logic                 bus_err;
    logic [3:0]           state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_we, ir_we, reg_we, mem_rd, mem_wr,
        output iord, reg_dst, mem_to_reg, alu_src_a, ext_sign,
        output alu_src_b, pc_src, alu_ctrl, illegal, bus_err, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_we, ir_we, reg_we, mem_rd, mem_wr,
        input  iord, reg_dst, mem_to_reg, alu_src_a, ext_sign,
        input  alu_src_b, pc_src, alu_ctrl, illegal, bus_err, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset control FSM with memory wait timeout
module mc_ctrl #(
    parameter int ALUCTRL_W       = 3,
    parameter int MEM_TIMEOUT     = 0,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_NOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SUB  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;
    localparam logic [2:0] ALU_XOR  = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t      state;
    logic [5:0]  op_q;
    logic [5:0]  funct_q;
    logic [31:0] wait_cnt;
    logic [31:0] wait_inc;
    logic        illegal_q;
    logic        bus_err_q;
    logic        timeout_hit;

    function automatic logic r_funct_ok(input logic [5:0] f);
        case (f)
            6'h20, 6'h22, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h26:   return ALU_XOR;
            6'h27:   return ALU_NOR;
            6'h2A:   return ALU_SLT;
            6'h2B:   return ALU_SLTU;
            default: return ALU_ADD;
        endcase
    endfunction

    // The cycle being evaluated counts as a waiting cycle, so the bound trips on the Nth one.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
                         (wait_cnt >= 32'(MEM_TIMEOUT - 1));
    assign wait_inc    = (&wait_cnt) ? wait_cnt : wait_cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            op_q      <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH: begin
                    if (bus.mem_ready) begin
                        state <= DECODE;
                    end else if (timeout_hit) begin
                        state     <= ILLEGAL;
                        illegal_q <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                DECODE: begin
                    op_q    <= bus.opcode;
                    funct_q <= bus.funct;
                    if (bus.opcode == OP_RTYPE && r_funct_ok(bus.funct)) begin
                        state <= EXEC_R;
                    end else begin
                        case (bus.opcode)
                            OP_LW, OP_SW:            state <= MEM_ADDR;
                            OP_BEQ, OP_BNE:          state <= BRANCH;
                            OP_ADDI, OP_SLTI, OP_ORI: state <= EXEC_I;
                            OP_J:                    state <= JUMP;
                            default: begin
                                state     <= ILLEGAL;
                                illegal_q <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC_R:   state <= WB_R;
                WB_R:     state <= FETCH;
                EXEC_I:   state <= WB_I;
                WB_I:     state <= FETCH;
                MEM_ADDR: state <= (op_q == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD: begin
                    if (bus.mem_ready) begin
                        state <= MEM_WB;
                    end else if (timeout_hit) begin
                        state     <= ILLEGAL;
                        illegal_q <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                MEM_WB:   state <= FETCH;
                MEM_WR: begin
                    if (bus.mem_ready) begin
                        state <= FETCH;
                    end else if (timeout_hit) begin
                        state     <= ILLEGAL;
                        illegal_q <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                BRANCH:   state <= FETCH;
                JUMP:     state <= FETCH;
                ILLEGAL: begin
                    if (HALT_ON_ILLEGAL == 0) state <= FETCH;
                end
                default: begin
                    state     <= ILLEGAL;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    logic       o_pc_we, o_ir_we, o_reg_we, o_mem_rd, o_mem_wr;
    logic       o_iord, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_ext_sign;
    logic [1:0] o_alu_src_b, o_pc_src;
    logic [2:0] o_alu;

    always_comb begin
        o_pc_we      = 1'b0;
        o_ir_we      = 1'b0;
        o_reg_we     = 1'b0;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_iord       = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src_a  = 1'b0;
        o_ext_sign   = 1'b0;
        o_alu_src_b  = 2'b00;
        o_pc_src     = 2'b00;
        o_alu        = ALU_ADD;
        case (state)
            FETCH: begin
                o_mem_rd    = 1'b1;
                o_alu_src_b = 2'b01;
                o_ir_we     = bus.mem_ready;
                o_pc_we     = bus.mem_ready;
            end
            DECODE: begin
                o_alu_src_b = 2'b11;
                o_ext_sign  = 1'b1;
            end
            EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu       = r_alu(funct_q);
            end
            WB_R: begin
                o_reg_we  = 1'b1;
                o_reg_dst = 1'b1;
            end
            EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                case (op_q)
                    OP_SLTI: begin o_alu = ALU_SLT; o_ext_sign = 1'b1; end
                    OP_ORI:  begin o_alu = ALU_OR;  o_ext_sign = 1'b0; end
                    default: begin o_alu = ALU_ADD; o_ext_sign = 1'b1; end
                endcase
            end
            WB_I:     o_reg_we = 1'b1;
            MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_ext_sign  = 1'b1;
            end
            MEM_RD: begin
                o_mem_rd = 1'b1;
                o_iord   = 1'b1;
            end
            MEM_WB: begin
                o_reg_we     = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                o_mem_wr = 1'b1;
                o_iord   = 1'b1;
            end
            BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu       = ALU_SUB;
                o_pc_src    = 2'b01;
                o_pc_we     = (op_q == OP_BEQ) ? bus.zero : !bus.zero;
            end
            JUMP: begin
                o_pc_src = 2'b10;
                o_pc_we  = 1'b1;
            end
            default: ;
        endcase
        // Strobes must be quiet for the whole reset cycle, not only after the edge.
        if (rst) begin
            o_pc_we  = 1'b0;
            o_ir_we  = 1'b0;
            o_reg_we = 1'b0;
            o_mem_rd = 1'b0;
            o_mem_wr = 1'b0;
        end
    end

    assign bus.pc_we      = o_pc_we;
    assign bus.ir_we      = o_ir_we;
    assign bus.reg_we     = o_reg_we;
    assign bus.mem_rd     = o_mem_rd;
    assign bus.mem_wr     = o_mem_wr;
    assign bus.iord       = o_iord;
    assign bus.reg_dst    = o_reg_dst;
    assign bus.mem_to_reg = o_mem_to_reg;
    assign bus.alu_src_a  = o_alu_src_a;
    assign bus.ext_sign   = o_ext_sign;
    assign bus.alu_src_b  = o_alu_src_b;
    assign bus.pc_src     = o_pc_src;
    assign bus.alu_ctrl   = ALUCTRL_W'(o_alu);
    assign bus.illegal    = illegal_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.state      = state;
endmodule
